// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU-side memory/IO controller for the SLC-3 datapath.
// Sits between MAR/MDR and an external asynchronous SRAM, offering the ISDU a
// req/ack handshake with WAIT_STATES extra SRAM cycles, and decodes IO_ADDR as
// a memory-mapped port (reads return Switches, writes load the hex register).
//
// Ports:
//   Clk, Reset          clock, asynchronous active-low reset
//   req, we, addr, wdata transaction request (sampled in IDLE only)
//   rdata, ack, busy    registered read data, 1-cycle done pulse, in-flight flag
//   Switches, hex_out   board switches in, hex display register out
//   CE UB LB OE WE      SRAM strobes, active-low
//   ADDR, Data          SRAM address and bidirectional data bus
//
// Optional feature macro: MEM_IO_BYTE_LANE_EN (requires DATA_W=16) adds a
// byte_en[1:0] input that gates the SRAM byte strobes, masks read data and
// masks I/O writes to hex_out per byte lane.
module mem_io_ctrl #(
  parameter int unsigned           DATA_W      = 16,
  parameter int unsigned           CPU_ADDR_W  = 16,
  parameter int unsigned           ADDR_W      = 20,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = 16'hFFFF,
  parameter int unsigned           NUM_HEX     = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [CPU_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  busy,
`ifdef MEM_IO_BYTE_LANE_EN
  input  logic [1:0]            byte_en,
`endif
  input  logic [DATA_W-1:0]     Switches,
  output logic [4*NUM_HEX-1:0]  hex_out,
  output logic                  CE,
  output logic                  UB,
  output logic                  LB,
  output logic                  OE,
  output logic                  WE,
  output logic [ADDR_W-1:0]     ADDR,
  inout  wire  [DATA_W-1:0]     Data
);

  localparam int unsigned HEX_W = 4 * NUM_HEX;

  typedef enum logic [1:0] {IDLE, IO, ACCESS, DONE} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                drive_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [HEX_W-1:0]    hex_q;
  logic                ack_q;
  logic                ce_n_q, ub_n_q, lb_n_q, oe_n_q, we_n_q;
  logic [ADDR_W-1:0]   sram_addr_q;

  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   rdata_d;
  logic [DATA_W-1:0]   io_rdata_d;
  logic [HEX_W-1:0]    hex_d;

`ifdef MEM_IO_BYTE_LANE_EN
  logic [1:0]          be_q;
  assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};
`else
  assign lane_mask = '1;
`endif

  // Disabled byte lanes read as zero; hex digits outside enabled lanes are kept.
  always_comb begin
    rdata_d    = Data & lane_mask;
    io_rdata_d = Switches & lane_mask;
    hex_d      = (hex_q & ~lane_mask[HEX_W-1:0]) | (wdata_q[HEX_W-1:0] & lane_mask[HEX_W-1:0]);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      rdata_q     <= '0;
      hex_q       <= '0;
      ack_q       <= 1'b0;
      ce_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
`ifdef MEM_IO_BYTE_LANE_EN
      be_q        <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            wdata_q <= wdata;
`ifdef MEM_IO_BYTE_LANE_EN
            be_q    <= byte_en;
`endif
            if (addr == IO_ADDR) begin
              state_q <= IO;
            end else begin
              // Strobes are registered, so they are set on the entry edge
              // to be valid for every ACCESS cycle.
              state_q     <= ACCESS;
              cnt_q       <= 4'(WAIT_STATES);
              sram_addr_q <= ADDR_W'(addr);
              ce_n_q      <= 1'b0;
`ifdef MEM_IO_BYTE_LANE_EN
              ub_n_q      <= ~byte_en[1];
              lb_n_q      <= ~byte_en[0];
              oe_n_q      <= we | ~(|byte_en);
              we_n_q      <= ~we | ~(|byte_en);
              drive_q     <= we & (|byte_en);
`else
              ub_n_q      <= 1'b0;
              lb_n_q      <= 1'b0;
              oe_n_q      <= we;
              we_n_q      <= ~we;
              drive_q     <= we;
`endif
            end
          end
        end
        IO: begin
          if (we_q) hex_q <= hex_d;
          else      rdata_q <= io_rdata_d;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) rdata_q <= rdata_d;
            ce_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Write data was held through DONE for SRAM hold time.
          drive_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data    = drive_q ? wdata_q : 'z;
  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign busy    = (state_q != IDLE);
  assign hex_out = hex_q;
  assign CE      = ce_n_q;
  assign UB      = ub_n_q;
  assign LB      = lb_n_q;
  assign OE      = oe_n_q;
  assign WE      = we_n_q;
  assign ADDR    = sram_addr_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: self-checking bench for mem_io_ctrl. An SRAM device model
// answers the strobes; a transaction-level reference (expected memory image,
// expected rdata and hex register) predicts every observable result.
module tb_mem_io_ctrl;
  localparam int unsigned WS = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req, we;
  logic [15:0] addr, wdata, Switches;
  logic [15:0] rdata, hex_out;
  logic        ack, busy;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;
`ifdef MEM_IO_BYTE_LANE_EN
  logic [1:0]  byte_en = 2'b11;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] sram    [0:255];
  logic [15:0] exp_mem [0:255];
  logic [15:0] exp_rdata, exp_hex;

  mem_io_ctrl #(.WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy),
`ifdef MEM_IO_BYTE_LANE_EN
    .byte_en(byte_en),
`endif
    .Switches(Switches), .hex_out(hex_out),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
  );

  always #5 Clk = ~Clk;

  // Asynchronous SRAM device: drives on CE&OE&!WE, writes while WE is low.
  assign Data = (!CE && !OE && WE) ? sram[ADDR[7:0]] : 'z;
  always @(negedge Clk) if (!CE && !WE) sram[ADDR[7:0]] <= Data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    int  cyc = 0, oe_lo = 0, we_lo = 0, act = 0;
    bit  got = 0, addr_ok = 1, data_ok = 1;
    bit  io = (a == 16'hFFFF);
    int  lat = io ? 2 : int'(WS) + 2;
    int  n = io ? 0 : int'(WS) + 1;
    @(negedge Clk);
    for (int t = 0; t < 20 && busy; t++) @(negedge Clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge Clk);
    #1;
    req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
    while (!got && cyc < 50) begin
      @(negedge Clk);
      cyc++;
      if (!OE) oe_lo++;
      if (!WE) we_lo++;
      if (!CE && !UB && !LB) act++;
      if (!CE && ADDR != 20'(a)) addr_ok = 0;
      if (!WE && Data != d) data_ok = 0;
      if (ack) begin
        got = 1;
        if (w && !io && Data != d) data_ok = 0;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    check("latency", cyc, lat);
    check("access_cycles", act, n);
    check("oe_cycles", oe_lo, (!io && !w) ? n : 0);
    check("we_cycles", we_lo, (!io && w) ? n : 0);
    if (!io) check("sram_addr", 32'(addr_ok), 32'd1);
    if (!io && w) check("write_data", 32'(data_ok), 32'd1);
    if (io) begin
      if (w) exp_hex = d; else exp_rdata = Switches;
    end else begin
      if (w) exp_mem[a[7:0]] = d; else exp_rdata = exp_mem[a[7:0]];
    end
    check("rdata", rdata, exp_rdata);
    check("hex_out", hex_out, exp_hex);
    @(negedge Clk);
    check("ack_pulse", {ack, busy}, 2'b00);
  endtask

  task automatic b2b_test();
    int ack_cyc[$];
    int cyc = 0, k = 0, idle_between = 0, addr_bad = 0;
    logic [15:0] cur = 16'd1;
    @(negedge Clk);
    req = 1'b1; we = 1'b0; addr = cur;
    while (k < 3 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (!CE && ADDR != 20'(cur)) addr_bad++;
      if (ack) begin
        check("b2b_rdata", rdata, exp_mem[cur[7:0]]);
        ack_cyc.push_back(cyc);
        k++;
        cur = cur + 16'd1;
        addr = cur;
        if (k == 3) req = 1'b0;
      end else if (busy) begin
        addr = 16'($urandom_range(100, 200));
      end else if (k > 0) begin
        idle_between++;
      end
    end
    exp_rdata = exp_mem[3];
    check("b2b_acks", k, 3);
    if (k == 3) begin
      check("b2b_gap1", ack_cyc[1] - ack_cyc[0], 5);
      check("b2b_gap2", ack_cyc[2] - ack_cyc[1], 5);
    end
    check("b2b_idle", idle_between, 2);
    check("b2b_addr_stable", addr_bad, 0);
  endtask

  task automatic reset_abort_test();
    @(negedge Clk);
    req = 1'b1; we = 1'b1; addr = 16'h00F0; wdata = 16'h5A5A;
    @(posedge Clk);
    #1 req = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_strobes", {CE, UB, LB, OE, WE}, 5'h1F);
    check("abort_ack", ack, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_hex", hex_out, 16'h0000);
    check("abort_addr", ADDR, 20'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("abort_no_ack", ack, 1'b0);
    end
    Reset = 1'b1;
    exp_rdata = '0;
    exp_hex   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 16'($urandom);
      exp_mem[i] = sram[i];
    end
    Reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; Switches = '0;
    exp_rdata = '0; exp_hex = '0;
    repeat (3) @(negedge Clk);
    check("rst_strobes", {CE, UB, LB, OE, WE}, 5'h1F);
    check("rst_addr", ADDR, 20'h0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_ack_busy", {ack, busy}, 2'b00);
    check("rst_hex", hex_out, 16'h0);
    Reset = 1'b1;

    sram[16'h10] = 16'hBEEF; exp_mem[16'h10] = 16'hBEEF;
    run_txn(1'b0, 16'h0010, 16'h0);
    check("read_beef", rdata, 16'hBEEF);

    run_txn(1'b1, 16'h0020, 16'h1234);
    run_txn(1'b0, 16'h0020, 16'h0);
    check("readback_1234", rdata, 16'h1234);
    check("addr_0020", ADDR, 20'h00020);

    Switches = 16'hA5C3;
    run_txn(1'b0, 16'hFFFF, 16'h0);
    check("io_read", rdata, 16'hA5C3);
    run_txn(1'b1, 16'hFFFF, 16'h00FF);
    check("io_write", hex_out, 16'h00FF);

    b2b_test();
    reset_abort_test();

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 239));
      Switches = 16'($urandom);
      run_txn(1'($urandom), a, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
